branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter BHT_ENTRIES, default 16, number of 2-bit predictor counters (power of two, 4..256).
REQ-002 Parameter FLUSH_CYCLES, default 2, cycles flush stays asserted after a mispredict (1..7).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Ports br_valid0 / br_valid1  input  1  branch present in issue slot 0 (older) / slot 1 (younger).
REQ-006 Ports br_op0 / br_op1  input  4  opcode per slot; 4'b1010 = BEQ, 4'b1011 = BNE.
REQ-007 Ports br_pc0 / br_pc1, br_target0 / br_target1  input  32  branch PC and taken target per slot.
REQ-008 Ports cmp_sel  output  1, cmp_op  output  4, cmp_pred  output  1  slot select, opcode and prediction driven to the shared compare unit.
REQ-009 Ports falseTaken, falseNotTaken, branchTaken  input  1  same-cycle result from the shared compare unit.
REQ-010 Port stall_slot1  output  1  slot-1 branch deferred one cycle; issue must hold slot 1.
REQ-011 Ports flush  output  1, redirect_valid  output  1, redirect_pc  output  32  pipeline recovery.
REQ-012 Ports lookup_pc  input  32, lookup_pred  output  1  fetch-side prediction query.

Function
REQ-013 A slot is a branch only when br_valid is high and its op is BEQ or BNE; other ops are ignored.
REQ-014 FSM states: IDLE, DEFER (slot-1 branch pending), RECOVER (flush counting).
REQ-015 IDLE, one branch: granted the same cycle; cmp_sel = slot index, cmp_op/cmp_pred from that slot.
REQ-016 IDLE, branches in both slots: slot 0 granted; stall_slot1 = 1; slot-1 PC/target/op/pred latched; next state DEFER.
REQ-017 DEFER: latched slot-1 branch granted (cmp_sel = 1); stall_slot1 = 0; new br_valid inputs ignored.
REQ-018 Prediction per slot = BHT counter MSB at the slot PC's index, captured at grant.
REQ-019 Mispredict = falseTaken or falseNotTaken on a granted cycle -> next cycle: redirect_valid = 1 for exactly one cycle, flush = 1 for FLUSH_CYCLES cycles, state RECOVER.
REQ-020 redirect_pc = granted target if falseNotTaken; granted PC + 4 if falseTaken (wraps modulo 2^32).
REQ-021 Slot-0 mispredict with slot-1 branch also present: slot-1 branch discarded, no DEFER, no slot-1 BHT update.
REQ-022 RECOVER: all br_valid ignored, stall_slot1 = 0; returns to IDLE when flush deasserts.
REQ-023 BHT index = pc[log2(BHT_ENTRIES)+1:2]; lookup_pred combinational from current table contents.
REQ-024 Every granted branch updates its counter one cycle after grant: taken -> +1 saturating at 3, not taken -> -1 saturating at 0.
REQ-025 Update and lookup to the same index in the same cycle: lookup_pred returns the pre-update value.
REQ-026 No branch granted: cmp_sel = 0, cmp_op = 4'b0000, cmp_pred = 0.

Reset
REQ-027 rst in any state -> next cycle: IDLE, flush = 0, redirect_valid = 0, redirect_pc = 0, stall_slot1 = 0, pending update cancelled.
REQ-028 rst initializes all BHT counters to 2'b01 (weakly not-taken); lookup_pred = 0 after reset.
REQ-029 Reset mid-RECOVER truncates the flush count; no redirect is reissued.

Structure
REQ-030 Opcode constants BEQ/BNE, FSM state encoding and counter reset value reside in the shared core package.
REQ-031 BHT (counter array, saturating update, lookup port) is one sub-module, branch_bht; FSM/arbitration stays in branch_ctrl.

Verification
REQ-032 Reset, then lookup_pc = 0x40 -> lookup_pred = 0; slot-0 BEQ at 0x40 taken twice -> counter 01->10->11, lookup_pred = 1.
REQ-033 Slot-0 BNE pc 0x100, target 0x200, pred 0, falseNotTaken = 1 -> redirect_valid 1 cycle with redirect_pc = 0x200, flush high 2 cycles.
REQ-034 Both slots BEQ, no mispredict -> stall_slot1 = 1 for one cycle, cmp_sel 0 then 1, both counters updated.
REQ-035 Both slots branch, slot 0 falseTaken at pc 0xFFFFFFFC -> redirect_pc = 0x00000000, slot 1 never granted, its counter unchanged.
REQ-036 rst asserted in first RECOVER cycle -> flush = 0 next cycle, IDLE, no second redirect_valid.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch-unit definitions: opcodes, FSM states,
// predictor reset value and the latched branch bundle.
package branch_pkg;

  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_NONE = 4'b0000;

  localparam logic [1:0] CTR_RST = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DEFER   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [3:0]  op;
    logic        pred;
  } br_t;

  function automatic logic is_branch(
    input logic       v,
    input logic [3:0] op
  );
    return v & ((op == OP_BEQ) | (op == OP_BNE));
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters with
// two slot read ports, a fetch lookup port and a delayed update.
module branch_bht
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd0_pc,
  input  logic [31:0] rd1_pc,
  input  logic [31:0] lookup_pc,
  output logic        rd0_pred,
  output logic        rd1_pred,
  output logic        lookup_pred,
  input  logic        upd_req,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken
);

  localparam int IW = $clog2(ENTRIES);

  logic [1:0]    ctr_q [ENTRIES];
  logic [1:0]    ctr_d [ENTRIES];
  logic          upd_v_q, upd_v_d;
  logic [IW-1:0] upd_idx_q, upd_idx_d;
  logic          upd_t_q, upd_t_d;
  logic [1:0]    cur;

  logic [IW-1:0] rd0_idx, rd1_idx, lk_idx;
  logic          unused_pc;

  assign rd0_idx = rd0_pc[IW+1:2];
  assign rd1_idx = rd1_pc[IW+1:2];
  assign lk_idx  = lookup_pc[IW+1:2];

  assign unused_pc = ^{rd0_pc[31:IW+2], rd0_pc[1:0],
                       rd1_pc[31:IW+2], rd1_pc[1:0],
                       lookup_pc[31:IW+2], lookup_pc[1:0],
                       upd_pc[31:IW+2], upd_pc[1:0]};

  // Reads see the table before this cycle's pending write lands.
  assign rd0_pred    = ctr_q[rd0_idx][1];
  assign rd1_pred    = ctr_q[rd1_idx][1];
  assign lookup_pred = ctr_q[lk_idx][1];

  always_comb begin
    ctr_d     = ctr_q;
    upd_v_d   = upd_req;
    upd_idx_d = upd_pc[IW+1:2];
    upd_t_d   = upd_taken;
    cur       = ctr_q[upd_idx_q];
    if (upd_v_q) begin
      if (upd_t_q && cur != 2'b11) begin
        ctr_d[upd_idx_q] = cur + 2'd1;
      end else if (!upd_t_q && cur != 2'b00) begin
        ctr_d[upd_idx_q] = cur - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_RST;
      end
      upd_v_q   <= 1'b0;
      upd_idx_q <= '0;
      upd_t_q   <= 1'b0;
    end else begin
      ctr_q     <= ctr_d;
      upd_v_q   <= upd_v_d;
      upd_idx_q <= upd_idx_d;
      upd_t_q   <= upd_t_d;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Dual-slot branch arbitration onto one compare unit, with
// slot-1 deferral, mispredict redirect/flush and BHT training.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid0,
  input  logic        br_valid1,
  input  logic [3:0]  br_op0,
  input  logic [3:0]  br_op1,
  input  logic [31:0] br_pc0,
  input  logic [31:0] br_pc1,
  input  logic [31:0] br_target0,
  input  logic [31:0] br_target1,
  output logic        cmp_sel,
  output logic [3:0]  cmp_op,
  output logic        cmp_pred,
  input  logic        falseTaken,
  input  logic        falseNotTaken,
  input  logic        branchTaken,
  output logic        stall_slot1,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic [31:0] lookup_pc,
  output logic        lookup_pred
);

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  br_t         slot1_q, slot1_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        rv_q, rv_d;
  logic [31:0] rpc_q, rpc_d;

  logic b0, b1;
  logic pred0, pred1;
  logic g_valid, g_sel, stall, mispredict;
  br_t  g;

  assign b0 = is_branch(br_valid0, br_op0);
  assign b1 = is_branch(br_valid1, br_op1);

  branch_bht #(
    .ENTRIES(BHT_ENTRIES)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd0_pc     (br_pc0),
    .rd1_pc     (br_pc1),
    .lookup_pc  (lookup_pc),
    .rd0_pred   (pred0),
    .rd1_pred   (pred1),
    .lookup_pred(lookup_pred),
    .upd_req    (g_valid),
    .upd_pc     (g.pc),
    .upd_taken  (branchTaken)
  );

  always_comb begin
    state_d    = state_q;
    slot1_d    = slot1_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q;
    rv_d       = 1'b0;
    rpc_d      = rpc_q;
    g_valid    = 1'b0;
    g_sel      = 1'b0;
    g          = '0;
    stall      = 1'b0;
    mispredict = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (b0) begin
          g_valid = 1'b1;
          g = '{br_pc0, br_target0, br_op0, pred0};
          if (b1) begin
            stall   = 1'b1;
            slot1_d = '{br_pc1, br_target1, br_op1, pred1};
            state_d = ST_DEFER;
          end
        end else if (b1) begin
          g_valid = 1'b1;
          g_sel   = 1'b1;
          g = '{br_pc1, br_target1, br_op1, pred1};
        end
      end
      ST_DEFER: begin
        g_valid = 1'b1;
        g_sel   = 1'b1;
        g       = slot1_q;
        state_d = ST_IDLE;
      end
      ST_RECOVER: begin
        if (cnt_q == 3'd0) begin
          flush_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A slot-0 mispredict overrides DEFER, dropping slot 1.
    mispredict = g_valid & (falseTaken | falseNotTaken);
    if (mispredict) begin
      state_d = ST_RECOVER;
      flush_d = 1'b1;
      cnt_d   = CNT_INIT;
      rv_d    = 1'b1;
      rpc_d   = falseNotTaken ? g.target : g.pc + 32'd4;
    end
  end

  assign cmp_sel        = g_sel;
  assign cmp_op         = g_valid ? g.op : OP_NONE;
  assign cmp_pred       = g_valid & g.pred;
  assign stall_slot1    = stall;
  assign flush          = flush_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      slot1_q <= '0;
      cnt_q   <= 3'd0;
      flush_q <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios plus random traffic
// against a behavioural model of the branch unit.
module tb_branch_ctrl;

  localparam int NB = 16;
  localparam int FC = 2;
  localparam logic [3:0] BEQ = 4'b1010;
  localparam logic [3:0] BNE = 4'b1011;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid0, br_valid1;
  logic [3:0]  br_op0, br_op1;
  logic [31:0] br_pc0, br_pc1, br_target0, br_target1;
  logic        cmp_sel, cmp_pred;
  logic [3:0]  cmp_op;
  logic        falseTaken, falseNotTaken, branchTaken;
  logic        stall_slot1, flush, redirect_valid;
  logic [31:0] redirect_pc, lookup_pc;
  logic        lookup_pred;

  always #5 clk = ~clk;

  branch_ctrl #(
    .BHT_ENTRIES (NB),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .br_valid0     (br_valid0),
    .br_valid1     (br_valid1),
    .br_op0        (br_op0),
    .br_op1        (br_op1),
    .br_pc0        (br_pc0),
    .br_pc1        (br_pc1),
    .br_target0    (br_target0),
    .br_target1    (br_target1),
    .cmp_sel       (cmp_sel),
    .cmp_op        (cmp_op),
    .cmp_pred      (cmp_pred),
    .falseTaken    (falseTaken),
    .falseNotTaken (falseNotTaken),
    .branchTaken   (branchTaken),
    .stall_slot1   (stall_slot1),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .lookup_pc     (lookup_pc),
    .lookup_pred   (lookup_pred)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int          bht [NB];
  bit          pend_v;
  int          pend_idx;
  bit          pend_t;
  int          mode;      // 0 idle, 1 slot-1 waiting, 2 recovering
  int          fl_left;
  bit          m_flush, m_rv, model_ok;
  logic [31:0] m_rpc;
  logic [31:0] d_pc, d_tgt;
  logic [3:0]  d_op;
  bit          d_pred;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'((pc / 4) % NB);
  endfunction

  function automatic bit isbr(input bit v, input logic [3:0] op);
    return v && (op == BEQ || op == BNE);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic step(
    input bit r,
    input bit v0, input logic [3:0] o0,
    input logic [31:0] p0, input logic [31:0] t0,
    input bit v1, input logic [3:0] o1,
    input logic [31:0] p1, input logic [31:0] t1,
    input logic [31:0] lpc, input bit tk
  );
    bit gv, gsel, gpred, dnew, stl, mis, ft, fnt;
    logic [3:0]  gop;
    logic [31:0] gpc, gtg;
    bit b0, b1;
    gv = 0; gsel = 0; gpred = 0; dnew = 0; stl = 0;
    gop = 4'h0; gpc = 0; gtg = 0;
    b0 = isbr(v0, o0);
    b1 = isbr(v1, o1);
    rst = r;
    br_valid0 = v0; br_op0 = o0; br_pc0 = p0; br_target0 = t0;
    br_valid1 = v1; br_op1 = o1; br_pc1 = p1; br_target1 = t1;
    lookup_pc = lpc;
    if (mode == 0) begin
      if (b0) begin
        gv = 1; gop = o0; gpc = p0; gtg = t0;
        gpred = bht[idx(p0)] >= 2;
        if (b1) begin
          stl = 1; dnew = 1;
        end
      end else if (b1) begin
        gv = 1; gsel = 1; gop = o1; gpc = p1; gtg = t1;
        gpred = bht[idx(p1)] >= 2;
      end
    end else if (mode == 1) begin
      gv = 1; gsel = 1; gop = d_op; gpc = d_pc; gtg = d_tgt;
      gpred = d_pred;
    end
    ft  = gv && gpred && !tk;
    fnt = gv && !gpred && tk;
    mis = ft || fnt;
    if (gv) begin
      falseTaken = ft; falseNotTaken = fnt; branchTaken = tk;
    end else begin
      falseTaken    = 1'($urandom_range(0, 1));
      falseNotTaken = 1'($urandom_range(0, 1));
      branchTaken   = 1'($urandom_range(0, 1));
    end
    #1;
    if (model_ok) begin
      chk("cmp_sel", cmp_sel, gsel);
      chk("cmp_op", cmp_op, gv ? gop : 4'h0);
      chk("cmp_pred", cmp_pred, gpred);
      chk("stall", stall_slot1, stl);
      chk("lookup", lookup_pred, bht[idx(lpc)] >= 2);
      chk("flush", flush, m_flush);
      chk("rv", redirect_valid, m_rv);
      chk("rpc", redirect_pc, m_rpc);
    end
    if (r) begin
      foreach (bht[i]) bht[i] = 1;
      pend_v = 0; mode = 0; fl_left = 0;
      m_flush = 0; m_rv = 0; m_rpc = 0;
      model_ok = 1;
    end else begin
      if (pend_v) begin
        if (pend_t) bht[pend_idx] = (bht[pend_idx] == 3) ? 3 : bht[pend_idx] + 1;
        else        bht[pend_idx] = (bht[pend_idx] == 0) ? 0 : bht[pend_idx] - 1;
      end
      pend_v = gv; pend_idx = idx(gpc); pend_t = tk;
      m_rv = 0;
      if (mis) begin
        m_rv = 1;
        m_rpc = fnt ? gtg : gpc + 32'd4;
        fl_left = FC; m_flush = 1; mode = 2;
      end else if (mode == 2) begin
        fl_left--;
        m_flush = fl_left > 0;
        if (fl_left == 0) mode = 0;
      end else begin
        mode = dnew ? 1 : 0;
      end
      if (dnew) begin
        d_pc = p1; d_tgt = t1; d_op = o1;
        d_pred = bht_pred_pre(p1, gv, gpc, tk);
      end
    end
  endtask

  // Slot-1 prediction is the table value seen during the grant cycle,
  // before the pending update just applied above.
  int bht_snap [NB];
  function automatic bit bht_pred_pre(input logic [31:0] pc, input bit a,
                                      input logic [31:0] b, input bit c);
    bit unused_args;
    unused_args = a ^ b[0] ^ c;
    return (bht_snap[idx(pc)] >= 2) | (unused_args & 1'b0);
  endfunction

  task automatic cyc(
    input bit r,
    input bit v0, input logic [3:0] o0,
    input logic [31:0] p0, input logic [31:0] t0,
    input bit v1, input logic [3:0] o1,
    input logic [31:0] p1, input logic [31:0] t1,
    input logic [31:0] lpc, input bit tk
  );
    bht_snap = bht;
    step(r, v0, o0, p0, t0, v1, o1, p1, t1, lpc, tk);
    tick();
  endtask

  task automatic go(
    input bit v0, input logic [3:0] o0,
    input logic [31:0] p0, input logic [31:0] t0,
    input bit v1, input logic [3:0] o1,
    input logic [31:0] p1, input logic [31:0] t1,
    input logic [31:0] lpc, input bit tk
  );
    bht_snap = bht;
    step(0, v0, o0, p0, t0, v1, o1, p1, t1, lpc, tk);
  endtask

  task automatic do_idle(input bit r);
    cyc(r, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 32'h40, 0);
  endtask

  function automatic logic [3:0] rop();
    case ($urandom_range(0, 3))
      0: return BEQ;
      1: return BNE;
      2: return 4'($urandom);
      default: return BEQ;
    endcase
  endfunction

  function automatic logic [31:0] rpc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return 32'($urandom_range(0, 31)) << 2;
  endfunction

  initial begin
    rst = 1; br_valid0 = 0; br_valid1 = 0;
    br_op0 = 0; br_op1 = 0; br_pc0 = 0; br_pc1 = 0;
    br_target0 = 0; br_target1 = 0; lookup_pc = 0;
    falseTaken = 0; falseNotTaken = 0; branchTaken = 0;
    model_ok = 0; mode = 0; pend_v = 0;
    tick();

    // Training a BHT entry with two taken branches
    do_idle(1); do_idle(1);
    chk("rst_flush", flush, 0);
    chk("rst_rv", redirect_valid, 0);
    chk("rst_rpc", redirect_pc, 0);
    go(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 32'h40, 0);
    chk("t1_lk0", lookup_pred, 0);
    tick();
    cyc(0, 1, BEQ, 32'h40, 32'h80, 0, 4'h0, 0, 0, 32'h40, 1);
    repeat (4) do_idle(0);
    go(1, BEQ, 32'h40, 32'h80, 0, 4'h0, 0, 0, 32'h40, 1);
    chk("t1_pred", cmp_pred, 1);
    tick();
    do_idle(0); do_idle(0);
    go(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 32'h40, 0);
    chk("t1_lk1", lookup_pred, 1);
    tick();

    // Not-taken prediction resolved taken
    do_idle(1);
    cyc(0, 1, BNE, 32'h100, 32'h200, 0, 4'h0, 0, 0, 32'h40, 1);
    chk("t2_rv", redirect_valid, 1);
    chk("t2_rpc", redirect_pc, 32'h200);
    chk("t2_fl1", flush, 1);
    do_idle(0);
    chk("t2_rv0", redirect_valid, 0);
    chk("t2_fl2", flush, 1);
    do_idle(0);
    chk("t2_fl0", flush, 0);

    // Two branches, slot 1 deferred
    do_idle(1);
    go(1, BEQ, 32'h10, 32'h50, 1, BEQ, 32'h20, 32'h60, 32'h40, 0);
    chk("t3_stall", stall_slot1, 1);
    chk("t3_sel0", cmp_sel, 0);
    tick();
    go(1, BNE, 32'h30, 32'h70, 1, BNE, 32'h34, 32'h74, 32'h40, 0);
    chk("t3_sel1", cmp_sel, 1);
    chk("t3_op1", cmp_op, BEQ);
    chk("t3_stall0", stall_slot1, 0);
    tick();
    do_idle(0);
    cyc(0, 1, BEQ, 32'h10, 32'h50, 0, 4'h0, 0, 0, 32'h40, 1);
    repeat (4) do_idle(0);
    go(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 32'h10, 0);
    chk("t3_upd", lookup_pred, 0);
    tick();

    // Slot-0 falseTaken at the top of the address space
    do_idle(1);
    cyc(0, 1, BEQ, 32'hFFFF_FFFC, 32'h8, 0, 4'h0, 0, 0, 32'h40, 1);
    repeat (4) do_idle(0);
    cyc(0, 1, BEQ, 32'h80, 32'h8, 0, 4'h0, 0, 0, 32'h40, 1);
    repeat (4) do_idle(0);
    go(1, BEQ, 32'hFFFF_FFFC, 32'h1234, 1, BNE, 32'h80, 32'h99, 32'h40, 0);
    chk("t4_pred", cmp_pred, 1);
    tick();
    chk("t4_rpc", redirect_pc, 32'h0);
    chk("t4_rv", redirect_valid, 1);
    go(1, BEQ, 32'hFFFF_FFFC, 32'h1234, 1, BNE, 32'h80, 32'h99, 32'h40, 1);
    chk("t4_op", cmp_op, 0);
    chk("t4_sel", cmp_sel, 0);
    tick();
    repeat (3) do_idle(0);
    go(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 32'h80, 0);
    chk("t4_s1ctr", lookup_pred, 1);
    tick();

    // Reset during the first recovery cycle
    do_idle(1);
    cyc(0, 1, BNE, 32'h100, 32'h200, 0, 4'h0, 0, 0, 32'h40, 1);
    do_idle(1);
    chk("t5_fl", flush, 0);
    chk("t5_rv", redirect_valid, 0);
    do_idle(0);
    chk("t5_rv2", redirect_valid, 0);
    chk("t5_fl2", flush, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 49) == 0,
          1'($urandom_range(0, 1)), rop(), rpc(), $urandom,
          1'($urandom_range(0, 1)), rop(), rpc(), $urandom,
          rpc(), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
